wb_regfile: RTL and testbench

- General-purpose register file at the receiving end of the writeback path.
- Accepts the single write per cycle produced by the writeback stage (wb_data plus destination and write-enable).
- Serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Tracks retirement: counts committed writes and latches a halt flag when the terminate marker arrives, so later writes are blocked.

---
 rtl/wb_regfile.sv | 94 +++++++++
 tb/tb_wb_regfile.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Architectural register file at the end of the writeback path.
// One write per cycle from writeback, two combinational read ports with
// same-cycle write-to-read bypass, a saturating count of committed writes,
// and a sticky halt that blocks all writes once the terminate marker retires.
module wb_regfile #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              wb_terminate,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic              halted,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic             commit;

  // A write only becomes architectural while running and when it targets a real register
  always_comb begin
    commit = wb_we && (state == RUN) && (wb_rd != '0);
  end

  // Run/halt sequencing together with register and counter updates; halted mirrors HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      halted   <= 1'b0;
      wr_count <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (commit) begin
        regs[wb_rd] <= wb_data;
        if (wr_count != {CNT_W{1'b1}}) begin
          wr_count <= wr_count + 1'b1;
        end
      end
      case (state)
        RUN: begin
          if (wb_terminate) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Read port 1: register 0 reads as zero, a committing write to the same index is forwarded
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (commit && (rs1_addr == wb_rd)) begin
      rs1_data = wb_data;
    end
  end

  // Read port 2: same zero-register and forwarding rules as port 1
  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (commit && (rs2_addr == wb_rd)) begin
      rs2_data = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a stimulus process drives one cycle at a
// time and queues the outputs a plain array model predicts; a monitor pops
// and compares on every falling edge. A narrow counter makes saturation reachable.
module tb_wb_regfile;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]  wb_data;
  logic              wb_terminate;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [WIDTH-1:0]  rs1_data;
  logic [WIDTH-1:0]  rs2_data;
  logic              halted;
  logic [CNT_W-1:0]  wr_count;

  typedef struct {
    logic             chk;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             h;
    logic [CNT_W-1:0] c;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             cur;
  int               checks = 0;
  int               errors = 0;

  logic [WIDTH-1:0] model_mem [NREGS];
  logic             model_halted = 1'b0;
  int               model_count  = 0;
  logic             model_known  = 1'b0;

  wb_regfile #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_terminate(wb_terminate),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .halted      (halted),
    .wr_count    (wr_count)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected read value from the architectural rules
  function automatic logic [WIDTH-1:0] readModel(input logic [ADDR_W-1:0] a, input logic we,
                                                  input logic [ADDR_W-1:0] rd, input logic [WIDTH-1:0] d);
    if (a == 0) return '0;
    if (we && !model_halted && rd != 0 && rd == a) return d;
    return model_mem[a];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the predicted outputs, then advance the model past the edge
  task automatic applyStimulus(input logic r, input logic we, input logic [ADDR_W-1:0] rd,
                               input logic [WIDTH-1:0] d, input logic t,
                               input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wb_we = we; wb_rd = rd; wb_data = d; wb_terminate = t;
    rs1_addr = a1; rs2_addr = a2;
    e.chk = model_known;
    e.r1  = readModel(a1, we, rd, d);
    e.r2  = readModel(a2, we, rd, d);
    e.h   = model_halted;
    e.c   = model_count[CNT_W-1:0];
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < NREGS; i++) model_mem[i] = '0;
      model_halted = 1'b0;
      model_count  = 0;
      model_known  = 1'b1;
    end else if (model_known) begin
      if (we && !model_halted && rd != 0) begin
        model_mem[rd] = d;
        if (model_count < CMAX) model_count++;
      end
      if (t) model_halted = 1'b1;
    end
  endtask

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.chk) begin
        checkOutput("rs1_data", 64'(rs1_data), 64'(cur.r1));
        checkOutput("rs2_data", 64'(rs2_data), 64'(cur.r2));
        checkOutput("halted",   64'(halted),   64'(cur.h));
        checkOutput("wr_count", 64'(wr_count), 64'(cur.c));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    rst = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0; wb_terminate = 1'b0;
    rs1_addr = '0; rs2_addr = '0;

    applyStimulus(1, 0, 0, 0, 0, 5, 31);
    applyStimulus(1, 0, 0, 0, 0, 5, 31);
    applyStimulus(0, 0, 0, 0, 0, 5, 31);

    applyStimulus(0, 1, 3, 32'hDEADBEEF, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 3, 3);

    applyStimulus(0, 1, 7, 32'h12345678, 0, 7, 7);
    applyStimulus(0, 0, 0, 0, 0, 7, 3);

    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 7);

    applyStimulus(0, 1, 4, 32'hA5, 1, 4, 4);
    applyStimulus(0, 1, 4, 32'h5A, 0, 4, 4);
    applyStimulus(0, 0, 0, 0, 1, 4, 3);

    applyStimulus(0, 1, 2, 32'h99, 0, 2, 4);
    applyStimulus(1, 1, 2, 32'h99, 0, 2, 4);
    applyStimulus(0, 0, 0, 0, 0, 2, 4);

    for (int i = 0; i < CMAX + 8; i++) begin
      applyStimulus(0, 1, 5'((i % 31) + 1), WIDTH'(i * 3 + 1), 0, 1, 5'((i % 31) + 1));
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 2);

    for (int i = 0; i < 1500; i++) begin
      rd = ADDR_W'($urandom_range(0, NREGS - 1));
      a1 = ($urandom_range(0, 9) < 4) ? rd : ADDR_W'($urandom_range(0, NREGS - 1));
      a2 = ($urandom_range(0, 9) < 4) ? rd : ADDR_W'($urandom_range(0, NREGS - 1));
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, rd, $urandom,
                    $urandom_range(0, 199) == 0, a1, a2);
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
